// File: rtl/warp_alloc_pkg.sv
// Shared types, widths and helpers for the warp allocation dispatcher.
package warp_alloc_pkg;

    localparam int unsigned NUM_HW_WARPS = 8;
    localparam int unsigned HW_ID_W      = 3;
    localparam int unsigned SW_WARP_W    = 8;
    localparam int unsigned NREQ_W       = 3;
    localparam int unsigned AVAIL_W      = 5;
    localparam int unsigned NEED_W       = 4;
    localparam int unsigned QDEPTH       = 4;
    localparam int unsigned TIMEOUT_CYC  = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [SW_WARP_W-1:0] sw;
        logic [NREQ_W-1:0]    nreq;
    } launch_entry_t;

    // The RAU hands out registers in pairs, so odd requests round up.
    function automatic logic [NEED_W-1:0] need_pairs(input logic [NREQ_W-1:0] nreq);
        return NEED_W'(nreq) + NEED_W'(nreq[0]);
    endfunction

endpackage

// File: rtl/launch_fifo.sv
// Synchronous launch-request FIFO; no bypass, push and pop may share a cycle.
module launch_fifo #(
    parameter int unsigned DW    = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
        if (pop_ok)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
        if (push_ok && !pop_ok)      count_d = CW'(count_q + 1'b1);
        else if (pop_ok && !push_ok) count_d = CW'(count_q - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/warp_alloc_dispatch.sv
// Binds queued warp launches to free HW slots and drives the RAU allocation handshake.
// Optional WAIT watchdog enabled by defining WARP_ALLOC_TIMEOUT_EN.
module warp_alloc_dispatch
    import warp_alloc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    LaunchValid_SCH_TM,
    input  logic [SW_WARP_W-1:0]    LaunchSWWarp_SCH_TM,
    input  logic [NREQ_W-1:0]       LaunchNreq_SCH_TM,
    output logic                    LaunchReady_TM_SCH,
    input  logic [AVAIL_W-1:0]      Available_RAU_TM,
    input  logic                    Req_Done_RAU_IB,
    input  logic                    ExitEN_IB_RAU,
    input  logic [HW_ID_W-1:0]      ExitWarpID_IB_RAU,
    output logic                    AlloEN_TM_RAU,
    output logic [NREQ_W-1:0]       Nreq_TM_RAU,
    output logic [HW_ID_W-1:0]      HWWarp_TM_RAU,
    output logic [SW_WARP_W-1:0]    SWWarp_TM_RAU,
    output logic [NUM_HW_WARPS-1:0] WarpActive_TM_IB,
    output logic                    LaunchDone_TM_IB,
    output logic [HW_ID_W-1:0]      LaunchDoneHW_TM_IB,
    output logic                    AllocErr_TM_IB
);

    state_t                  state_q, state_d;
    logic [NUM_HW_WARPS-1:0] active_q, active_d;
    logic [HW_ID_W-1:0]      hw_q, hw_d;
    logic [SW_WARP_W-1:0]    sw_q, sw_d;
    logic [NREQ_W-1:0]       nreq_q, nreq_d;
    logic                    blank_q, blank_d;
    logic                    done_q, done_d;
    logic [HW_ID_W-1:0]      done_hw_q, done_hw_d;

    launch_entry_t           push_data_c, head_c;
    logic                    fifo_full, fifo_empty;
    logic                    push_c, pop_c, launch_ok_c, alloen_c;
    logic                    free_any_c;
    logic [HW_ID_W-1:0]      free_hw_c;

`ifdef WARP_ALLOC_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    assign push_data_c = '{sw: LaunchSWWarp_SCH_TM, nreq: LaunchNreq_SCH_TM};
    assign push_c      = LaunchValid_SCH_TM && LaunchReady_TM_SCH;

    launch_fifo #(
        .DW    ($bits(launch_entry_t)),
        .DEPTH (QDEPTH)
    ) u_launch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push_c),
        .wr_data_i (push_data_c),
        .pop_i     (pop_c),
        .rd_data_o (head_c),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Lowest-index free slot, taken from the registered (pre-exit) bitmap.
    always_comb begin
        free_any_c = |(~active_q);
        free_hw_c  = '0;
        for (int i = NUM_HW_WARPS - 1; i >= 0; i--) begin
            if (!active_q[i]) free_hw_c = HW_ID_W'(i);
        end
    end

    assign launch_ok_c = !fifo_empty && free_any_c &&
                         (Available_RAU_TM >= AVAIL_W'(need_pairs(head_c.nreq)));
    assign pop_c       = (state_q == ST_IDLE) && launch_ok_c;
    // The RAU services exits first, so the strobe yields to ExitEN in the same cycle.
    assign alloen_c    = (state_q == ST_ISSUE) && !ExitEN_IB_RAU;

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        hw_d      = hw_q;
        sw_d      = sw_q;
        nreq_d    = nreq_q;
        blank_d   = blank_q;
        done_d    = 1'b0;
        done_hw_d = done_hw_q;
`ifdef WARP_ALLOC_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = err_q;
`endif

        if (ExitEN_IB_RAU && active_q[ExitWarpID_IB_RAU]) begin
            active_d[ExitWarpID_IB_RAU] = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (launch_ok_c) begin
                    state_d = ST_ISSUE;
                    hw_d    = free_hw_c;
                    sw_d    = head_c.sw;
                    nreq_d  = head_c.nreq;
                end
            end
            ST_ISSUE: begin
                if (alloen_c) begin
                    state_d        = ST_WAIT;
                    active_d[hw_q] = 1'b1;
                    blank_d        = 1'b1;
`ifdef WARP_ALLOC_TIMEOUT_EN
                    tmo_d          = '0;
`endif
                end
            end
            ST_WAIT: begin
                // Req_Done is ignored in the strobe cycle and the one after it.
                if (blank_q) begin
                    blank_d = 1'b0;
                end else if (Req_Done_RAU_IB) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    done_hw_d = hw_q;
                end
`ifdef WARP_ALLOC_TIMEOUT_EN
                tmo_d = TMO_W'(tmo_q + 1'b1);
                if ((state_d == ST_WAIT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1))) begin
                    state_d        = ST_IDLE;
                    err_d          = 1'b1;
                    active_d[hw_q] = 1'b0;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            active_q  <= '0;
            hw_q      <= '0;
            sw_q      <= '0;
            nreq_q    <= '0;
            blank_q   <= 1'b0;
            done_q    <= 1'b0;
            done_hw_q <= '0;
`ifdef WARP_ALLOC_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            hw_q      <= hw_d;
            sw_q      <= sw_d;
            nreq_q    <= nreq_d;
            blank_q   <= blank_d;
            done_q    <= done_d;
            done_hw_q <= done_hw_d;
`ifdef WARP_ALLOC_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    assign LaunchReady_TM_SCH = !rst && !fifo_full;
    assign AlloEN_TM_RAU      = alloen_c;
    assign Nreq_TM_RAU        = nreq_q;
    assign HWWarp_TM_RAU      = hw_q;
    assign SWWarp_TM_RAU      = sw_q;
    assign WarpActive_TM_IB   = active_q;
    assign LaunchDone_TM_IB   = done_q;
    assign LaunchDoneHW_TM_IB = done_hw_q;
`ifdef WARP_ALLOC_TIMEOUT_EN
    assign AllocErr_TM_IB     = err_q;
`else
    assign AllocErr_TM_IB     = 1'b0;
`endif

endmodule

// File: tb/tb_warp_alloc_dispatch.sv
// Self-checking bench for warp_alloc_dispatch: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_warp_alloc_dispatch;

    logic       clk = 1'b0;
    logic       rst;
    logic       LaunchValid;
    logic [7:0] LaunchSW;
    logic [2:0] LaunchNreq;
    logic       LaunchReady;
    logic [4:0] Available;
    logic       ReqDone;
    logic       ExitEN;
    logic [2:0] ExitID;
    logic       AlloEN;
    logic [2:0] NreqOut;
    logic [2:0] HWOut;
    logic [7:0] SWOut;
    logic [7:0] WarpActive;
    logic       LaunchDone;
    logic [2:0] LaunchDoneHW;
    logic       AllocErr;

    always #5 clk = ~clk;

    warp_alloc_dispatch dut (
        .clk                 (clk),
        .rst                 (rst),
        .LaunchValid_SCH_TM  (LaunchValid),
        .LaunchSWWarp_SCH_TM (LaunchSW),
        .LaunchNreq_SCH_TM   (LaunchNreq),
        .LaunchReady_TM_SCH  (LaunchReady),
        .Available_RAU_TM    (Available),
        .Req_Done_RAU_IB     (ReqDone),
        .ExitEN_IB_RAU       (ExitEN),
        .ExitWarpID_IB_RAU   (ExitID),
        .AlloEN_TM_RAU       (AlloEN),
        .Nreq_TM_RAU         (NreqOut),
        .HWWarp_TM_RAU       (HWOut),
        .SWWarp_TM_RAU       (SWOut),
        .WarpActive_TM_IB    (WarpActive),
        .LaunchDone_TM_IB    (LaunchDone),
        .LaunchDoneHW_TM_IB  (LaunchDoneHW),
        .AllocErr_TM_IB      (AllocErr)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of pending launches, a bitmap of occupied slots and
    // one outstanding allocation tracked by the cycle number of its strobe.
    typedef struct {
        logic [7:0] sw;
        logic [2:0] nreq;
    } ent_t;

    localparam int TMO = 64;

    ent_t       mq[$];
    logic [7:0] m_act     = '0;
    bit         m_busy    = 0;
    bit         m_strobed = 0;
    bit         m_done    = 0;
    bit         m_err     = 0;
    bit         m_known   = 0;
    bit         m_accept  = 0;
    int         m_strobe_cyc = 0;
    int         cyc = 0;
    logic [2:0] m_hw = '0, m_done_hw = '0, m_nreq = '0;
    logic [7:0] m_sw = '0;

    function automatic int need_of(input int n);
        return ((n + 1) / 2) * 2;
    endfunction

    task automatic sample();
        logic [7:0] pre;
        bit         exp_ready, acc, dn;
        @(negedge clk);
        exp_ready = !rst && (mq.size() < 4);
        if (m_known) begin
            chk("ready",  32'(LaunchReady), 32'(exp_ready));
            chk("alloen", 32'(AlloEN), 32'(m_busy && !m_strobed && !ExitEN));
            chk("active", 32'(WarpActive), 32'(m_act));
            chk("done",   32'(LaunchDone), 32'(m_done));
            chk("err",    32'(AllocErr), 32'(m_err));
            if (m_done) chk("done_hw", 32'(LaunchDoneHW), 32'(m_done_hw));
            if (m_busy || m_done) begin
                chk("hw",   32'(HWOut), 32'(m_hw));
                chk("sw",   32'(SWOut), 32'(m_sw));
                chk("nreq", 32'(NreqOut), 32'(m_nreq));
            end
        end
        if (rst) begin
            mq.delete();
            m_act = '0; m_busy = 0; m_strobed = 0; m_done = 0; m_err = 0;
            m_hw = '0; m_sw = '0; m_nreq = '0; m_done_hw = '0;
            m_accept = 0; m_known = 1;
        end else begin
            pre = m_act;
            acc = LaunchValid && exp_ready;
            dn  = 0;
            if (!m_busy) begin
                if (mq.size() > 0 && pre != 8'hFF &&
                    int'(Available) >= need_of(int'(mq[0].nreq))) begin
                    for (int i = 7; i >= 0; i--) if (!pre[i]) m_hw = 3'(i);
                    m_sw   = mq[0].sw;
                    m_nreq = mq[0].nreq;
                    void'(mq.pop_front());
                    m_busy = 1; m_strobed = 0;
                end
            end else if (!m_strobed) begin
                if (!ExitEN) begin
                    m_strobed = 1; m_strobe_cyc = cyc; m_act[m_hw] = 1'b1;
                end
            end else if (cyc >= m_strobe_cyc + 2 && ReqDone) begin
                dn = 1; m_done_hw = m_hw; m_busy = 0; m_strobed = 0;
            end
`ifdef WARP_ALLOC_TIMEOUT_EN
            else if (cyc == m_strobe_cyc + TMO) begin
                m_err = 1; m_act[m_hw] = 1'b0; m_busy = 0; m_strobed = 0;
            end
`endif
            if (ExitEN && pre[ExitID]) m_act[ExitID] = 1'b0;
            if (acc) mq.push_back('{sw: LaunchSW, nreq: LaunchNreq});
            m_done   = dn;
            m_accept = acc;
        end
        cyc++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            sample();
            adv();
        end
    endtask

    task automatic quiet();
        LaunchValid = 0; ExitEN = 0; ExitID = '0; ReqDone = 0;
    endtask

    task automatic do_reset();
        rst = 1; run(2); rst = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pushes;
        rst = 1; quiet(); LaunchSW = '0; LaunchNreq = '0; Available = 5'd16;
        run(2);
        sample();
        chk("rst_ready",  32'(LaunchReady), 32'd0);
        chk("rst_active", 32'(WarpActive), 32'd0);
        adv();
        rst = 0;
        sample();
        chk("post_rst_ready",  32'(LaunchReady), 32'd1);
        chk("post_rst_alloen", 32'(AlloEN), 32'd0);
        chk("post_rst_done",   32'(LaunchDone), 32'd0);
        adv();

        // Single launch: strobe two cycles after acceptance, done three after strobe.
        LaunchValid = 1; LaunchSW = 8'h21; LaunchNreq = 3'd3; Available = 5'd16;
        sample(); adv();
        LaunchValid = 0;
        sample(); chk("s1_no_strobe_yet", 32'(AlloEN), 32'd0); adv();
        sample();
        chk("s1_alloen", 32'(AlloEN), 32'd1);
        chk("s1_hw",     32'(HWOut), 32'd0);
        chk("s1_nreq",   32'(NreqOut), 32'd3);
        chk("s1_sw",     32'(SWOut), 32'h21);
        adv();
        run(1);
        ReqDone = 1;
        sample(); adv();
        ReqDone = 0;
        sample();
        chk("s1_done",    32'(LaunchDone), 32'd1);
        chk("s1_done_hw", 32'(LaunchDoneHW), 32'd0);
        chk("s1_active",  32'(WarpActive), 32'h01);
        adv();

        // Fill all slots; the extra launch has to wait.
        Available = 5'd31; ReqDone = 1; pushes = 0;
        for (int k = 0; k < 200 && pushes < 8; k++) begin
            LaunchValid = 1; LaunchSW = 8'(8'h40 + pushes); LaunchNreq = 3'(pushes);
            sample();
            if (m_accept) pushes++;
            adv();
        end
        LaunchValid = 0;
        run(40);
        sample();
        chk("fill_active",  32'(WarpActive), 32'hFF);
        chk("ninth_waits",  32'(AlloEN), 32'd0);
        adv();
        ExitEN = 1; ExitID = 3'd5;
        sample(); adv();
        ExitEN = 0;
        run(1);
        sample();
        chk("rebind_alloen", 32'(AlloEN), 32'd1);
        chk("rebind_hw",     32'(HWOut), 32'd5);
        adv();
        run(6);

        // Insufficient RAU pairs hold the head until Available rises.
        ExitEN = 1; ExitID = 3'd3; Available = 5'd2;
        LaunchValid = 1; LaunchSW = 8'h77; LaunchNreq = 3'd3;
        sample(); adv();
        ExitEN = 0; LaunchValid = 0;
        for (int k = 0; k < 5; k++) begin
            sample(); chk("avail_block", 32'(AlloEN), 32'd0); adv();
        end
        Available = 5'd4;
        sample(); adv();
        sample();
        chk("avail_ok",    32'(AlloEN), 32'd1);
        chk("avail_ok_hw", 32'(HWOut), 32'd3);
        adv();
        run(6);

        // Exit strobes during ISSUE defer AlloEN.
        Available = 5'd31;
        ExitEN = 1; ExitID = 3'd2; LaunchValid = 1; LaunchSW = 8'h55; LaunchNreq = 3'd1;
        sample(); adv();
        ExitEN = 0; LaunchValid = 0;
        sample(); adv();
        ExitEN = 1; ExitID = 3'd2;
        for (int k = 0; k < 3; k++) begin
            sample(); chk("exit_defer", 32'(AlloEN), 32'd0); adv();
        end
        ExitEN = 0;
        sample();
        chk("exit_release",    32'(AlloEN), 32'd1);
        chk("exit_release_hw", 32'(HWOut), 32'd2);
        adv();
        run(6);

        // Queue fills while every slot is occupied.
        for (int k = 0; k < 5; k++) begin
            LaunchValid = 1; LaunchSW = 8'(8'h90 + k); LaunchNreq = 3'd2;
            sample();
            chk(k == 4 ? "full_ready" : "fill_ready", 32'(LaunchReady), (k == 4) ? 32'd0 : 32'd1);
            adv();
        end
        run(3);
        ExitEN = 1; ExitID = 3'd0;
        sample(); adv();
        ExitEN = 0;
        for (int k = 0; k < 10; k++) begin
            sample();
            adv();
            if (m_accept) break;
        end
        LaunchValid = 0;
        run(10);

        // Reset in WAIT drops the allocation without a LaunchDone.
        do_reset();
        ReqDone = 0; LaunchValid = 1; LaunchSW = 8'hA5; LaunchNreq = 3'd4;
        sample(); adv();
        LaunchValid = 0;
        run(3);
        rst = 1; run(2); rst = 0;
        sample();
        chk("midwait_active", 32'(WarpActive), 32'd0);
        chk("midwait_done",   32'(LaunchDone), 32'd0);
        adv();
        run(5);

`ifdef WARP_ALLOC_TIMEOUT_EN
        ReqDone = 0; LaunchValid = 1; LaunchSW = 8'h3C; LaunchNreq = 3'd2;
        sample(); adv();
        LaunchValid = 0;
        run(80);
        sample();
        chk("tmo_err",    32'(AllocErr), 32'd1);
        chk("tmo_active", 32'(WarpActive), 32'd0);
        adv();
        do_reset();
`endif

        // Random traffic.
        for (int k = 0; k < 2500; k++) begin
            rst         = ($urandom_range(0, 499) == 0);
            LaunchValid = $urandom_range(0, 1) == 1;
            LaunchSW    = 8'($urandom);
            LaunchNreq  = 3'($urandom);
            Available   = 5'($urandom_range(0, 12));
            ExitEN      = ($urandom_range(0, 3) == 0);
            ExitID      = 3'($urandom);
            ReqDone     = ($urandom_range(0, 2) == 0);
            sample();
            adv();
        end
        quiet(); rst = 0;
        run(10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
